// File: rtl/mulf_pkg.sv
// Shared types and constants for the sequential FP32 multiplier and its
// normalize/round stage.
package mulf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    localparam int FP_W        = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_FRAC_W   = 23;
    localparam int FP_SIGN_BIT = FP_W - 1;

    localparam int FP_BIAS    = 127;
    localparam int EXP_MAX    = 255;
    localparam int MUL_CYCLES = 24;

    // Magnitude patterns; the sign bit is prepended by the user.
    localparam logic [FP_W-2:0] FP_QINF_MAG = 31'h7F80_0000;
    localparam logic [FP_W-2:0] FP_ZERO_MAG = '0;

endpackage

// File: rtl/mulf_norm_round.sv
// Combinational normalize, optional round-to-nearest-even (MULF_ROUND_NEAREST_EN)
// and exception packing of a 48-bit mantissa product into an FP32 result.
module mulf_norm_round
    import mulf_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_FRAC_W
) (
    input  logic                       i_sign,
    input  logic signed [EXP_W+1:0]    i_exp,
    input  logic [2*MANT_W+1:0]        i_prod,
    input  logic                       i_zero,
    input  logic                       i_inf,
    output logic [EXP_W+MANT_W:0]      o_s,
    output logic                       o_ovf,
    output logic                       o_unf
);

    localparam int PW = 2 * (MANT_W + 1);
    localparam logic signed [EXP_W+1:0] EXP_OVF = (EXP_W + 2)'(EXP_MAX);

    logic                    w_hi;
    logic [MANT_W-1:0]       w_frac_trn;
    logic [MANT_W-1:0]       w_frac;
    logic signed [EXP_W+1:0] w_exp_trn;
    logic signed [EXP_W+1:0] w_exp;

    // Product of two [1,2) mantissas lies in [1,4): the top bit picks the shift.
    assign w_hi       = i_prod[PW-1];
    assign w_frac_trn = w_hi ? i_prod[PW-2 -: MANT_W] : i_prod[PW-3 -: MANT_W];
    assign w_exp_trn  = i_exp + {{(EXP_W+1){1'b0}}, w_hi};

`ifdef MULF_ROUND_NEAREST_EN
    logic            w_guard;
    logic            w_sticky;
    logic            w_inc;
    logic [MANT_W:0] w_frac_rnd;

    assign w_guard    = w_hi ? i_prod[PW-2-MANT_W] : i_prod[PW-3-MANT_W];
    assign w_sticky   = w_hi ? (|i_prod[PW-3-MANT_W:0]) : (|i_prod[PW-4-MANT_W:0]);
    assign w_inc      = w_guard & (w_sticky | w_frac_trn[0]);
    assign w_frac_rnd = {1'b0, w_frac_trn} + {{MANT_W{1'b0}}, w_inc};
    // A carry out means the mantissa rolled over to 2.0: fraction wraps to 0.
    assign w_frac     = w_frac_rnd[MANT_W-1:0];
    assign w_exp      = w_exp_trn + {{(EXP_W+1){1'b0}}, w_frac_rnd[MANT_W]};
`else
    logic w_unused_low;

    assign w_unused_low = ^i_prod[PW-4-MANT_W:0];
    assign w_frac       = w_frac_trn;
    assign w_exp        = w_exp_trn;
`endif

    always_comb begin
        o_s   = '0;
        o_ovf = 1'b0;
        o_unf = 1'b0;
        if (i_zero) begin
            o_s = {i_sign, FP_ZERO_MAG};
        end else if (i_inf) begin
            o_s   = {i_sign, FP_QINF_MAG};
            o_ovf = 1'b1;
        end else if (w_exp >= EXP_OVF) begin
            o_s   = {i_sign, FP_QINF_MAG};
            o_ovf = 1'b1;
        end else if (w_exp[EXP_W+1] || (w_exp == '0)) begin
            o_s   = {i_sign, FP_ZERO_MAG};
            o_unf = 1'b1;
        end else begin
            o_s = {i_sign, w_exp[EXP_W-1:0], w_frac};
        end
    end

endmodule

// File: rtl/mulf_seq.sv
// Sequential FP32 multiplier: 24-cycle shift-add mantissa product, one
// normalize cycle, start/busy/done handshake. Rounding mode via MULF_ROUND_NEAREST_EN.
module mulf_seq
    import mulf_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_FRAC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [EXP_W+MANT_W:0] s,
    output logic                  ovf,
    output logic                  unf
);

    localparam int PW = 2 * (MANT_W + 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_sign;
    logic signed [EXP_W+1:0] r_exp;
    logic [MANT_W:0]         r_ma;
    logic [MANT_W:0]         r_mb;
    logic [PW-1:0]           r_acc;
    logic [4:0]              r_cnt;
    logic                    r_zero;
    logic                    r_inf;
    logic                    r_done;
    logic [EXP_W+MANT_W:0]   r_s;
    logic                    r_ovf;
    logic                    r_unf;

    logic [EXP_W-1:0]        w_ea;
    logic [EXP_W-1:0]        w_eb;
    logic signed [EXP_W+1:0] w_exp_sum;
    logic [PW-1:0]           w_addend;
    logic                    w_last;
    logic [EXP_W+MANT_W:0]   w_s;
    logic                    w_ovf;
    logic                    w_unf;

    assign w_ea      = a[EXP_W+MANT_W-1 -: EXP_W];
    assign w_eb      = b[EXP_W+MANT_W-1 -: EXP_W];
    // Unsigned wrap in EXP_W+2 bits yields the correct two's-complement sum.
    assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - (EXP_W + 2)'(FP_BIAS);
    assign w_addend  = {{(MANT_W+1){1'b0}}, r_ma} << r_cnt;
    assign w_last    = (r_cnt == 5'(MUL_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = MUL;
            MUL:     if (w_last) w_state_next = NORM;
            NORM:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_inf  <= 1'b0;
            r_done <= 1'b0;
            r_s    <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= a[FP_SIGN_BIT] ^ b[FP_SIGN_BIT];
                        r_exp  <= w_exp_sum;
                        r_ma   <= {1'b1, a[MANT_W-1:0]};
                        r_mb   <= {1'b1, b[MANT_W-1:0]};
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_zero <= (w_ea == '0) || (w_eb == '0);
                        r_inf  <= (w_ea == '1) || (w_eb == '1);
                    end
                end
                MUL: begin
                    if (r_mb[0]) r_acc <= r_acc + w_addend;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: begin
                    r_s    <= w_s;
                    r_ovf  <= w_ovf;
                    r_unf  <= w_unf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    mulf_norm_round #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_norm (
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_prod (r_acc),
        .i_zero (r_zero),
        .i_inf  (r_inf),
        .o_s    (w_s),
        .o_ovf  (w_ovf),
        .o_unf  (w_unf)
    );

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign s    = r_s;
    assign ovf  = r_ovf;
    assign unf  = r_unf;

endmodule
